// File: rtl/lab2_pkg.sv
// Shared constants and state encoding for the key press controller.
// Imported by the controller, its interface and the bench.
package lab2_pkg;

  localparam int SW_W  = 10;
  localparam int CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE         = 2'd0;
  localparam state_t PRESS_WAIT   = 2'd1;
  localparam state_t PRESSED      = 2'd2;
  localparam state_t RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/key_press_ctrl_if.sv
// Bundle of the key/switch inputs and the write-side outputs.
// master drives the button and switches, slave is the controller.
interface key_press_ctrl_if;
  import lab2_pkg::*;

  logic             key;
  logic [SW_W-1:0]  sw;
  logic             we;
  logic [SW_W-1:0]  data;
  logic [CNT_W-1:0] press_cnt;
  logic             busy;

  modport master (
    output key, sw,
    input  we, data, press_cnt, busy
  );

  modport slave (
    input  key, sw,
    output we, data, press_cnt, busy
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw push-button.
// Both flops clear to 0 on reset.
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_press_ctrl.sv
// Debounced push-button controller: one write strobe per accepted
// press, capturing the switch word and counting presses.
module key_press_ctrl
  import lab2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk100_i,
  input  logic             rstn_i,
  input  logic             key_i,
  input  logic [SW_W-1:0]  sw_i,
  output logic             we_o,
  output logic [SW_W-1:0]  data_o,
  output logic [CNT_W-1:0] press_cnt_o,
  output logic             busy_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          k_s;
  state_t        state;
  state_t        nxt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;
  logic          strobe;

  key_sync u_sync (
    .clk   (clk100_i),
    .rst_n (rstn_i),
    .d     (key_i),
    .q     (k_s)
  );

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt tops out at LAST, so it can never wrap
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (k_s) begin
          nxt     = PRESS_WAIT;
          cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!k_s)
          nxt = IDLE;
        else if (cnt == LAST)
          nxt = PRESSED;
        else
          cnt_nxt = cnt + DW'(1);
      end
      PRESSED: begin
        if (!k_s) begin
          nxt     = RELEASE_WAIT;
          cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (k_s)
          nxt = PRESSED;
        else if (cnt == LAST)
          nxt = IDLE;
        else
          cnt_nxt = cnt + DW'(1);
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    strobe = (state == PRESS_WAIT) && k_s && (cnt == LAST);
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      we_o        <= 1'b0;
      data_o      <= '0;
      press_cnt_o <= '0;
    end else begin
      we_o <= strobe;
      if (strobe) begin
        data_o      <= sw_i;
        press_cnt_o <= press_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_press_ctrl.sv
// Directed bench for key_press_ctrl with a strobe scoreboard.
// DEBOUNCE_CYCLES = 4, 10 ns clock.
module tb_key_press_ctrl;
  import lab2_pkg::*;

  logic clk;
  logic rstn;

  key_press_ctrl_if ifc ();

  key_press_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk100_i    (clk),
    .rstn_i      (rstn),
    .key_i       (ifc.key),
    .sw_i        (ifc.sw),
    .we_o        (ifc.we),
    .data_o      (ifc.data),
    .press_cnt_o (ifc.press_cnt),
    .busy_o      (ifc.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_we     = 0;
  logic [17:0] sbq[$];
  logic [7:0]  exp_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_press(input logic [9:0] s);
    exp_cnt = exp_cnt + 8'd1;
    sbq.push_back({s, exp_cnt});
  endtask

  task automatic press(input logic [9:0] s, input int hold);
    ifc.sw = s;
    expect_press(s);
    ifc.key = 1'b1;
    repeat (hold) step();
    ifc.key = 1'b0;
    repeat (12) step();
  endtask

  logic [17:0] e;
  always @(negedge clk) begin
    if (ifc.we === 1'b1) begin
      n_we++;
      if (sbq.size() == 0) begin
        chk("unexpected_we", 32'(ifc.we), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", 32'(ifc.data), 32'(e[17:8]));
        chk("sb_cnt", 32'(ifc.press_cnt), 32'(e[7:0]));
      end
    end
  end

  int we0;

  initial begin
    rstn    = 1'b0;
    ifc.key = 1'b0;
    ifc.sw  = 10'h0;
    repeat (3) step();
    chk("rst_we", 32'(ifc.we), 32'd0);
    chk("rst_data", 32'(ifc.data), 32'd0);
    chk("rst_cnt", 32'(ifc.press_cnt), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    rstn = 1'b1;
    repeat (2) step();

    // clean press with latency check
    ifc.sw = 10'h2A5;
    expect_press(10'h2A5);
    ifc.key = 1'b1;
    repeat (6) step();
    chk("lat_early", 32'(ifc.we), 32'd0);
    step();
    chk("lat_strobe", 32'(ifc.we), 32'd1);
    chk("lat_busy", 32'(ifc.busy), 32'd1);
    step();
    chk("one_cycle", 32'(ifc.we), 32'd0);
    repeat (12) step();
    ifc.key = 1'b0;
    repeat (12) step();
    chk("clean_busy", 32'(ifc.busy), 32'd0);
    chk("clean_data", 32'(ifc.data), 32'h2A5);
    chk("clean_cnt", 32'(ifc.press_cnt), 32'd1);

    // switch change while held, then bouncy release
    ifc.sw = 10'h155;
    expect_press(10'h155);
    ifc.key = 1'b1;
    repeat (8) step();
    ifc.sw = 10'h3FF;
    repeat (6) step();
    chk("held_data", 32'(ifc.data), 32'h155);
    for (int i = 0; i < 6; i++) begin
      ifc.key = ~ifc.key;
      step();
    end
    ifc.key = 1'b0;
    repeat (12) step();
    chk("rel_data", 32'(ifc.data), 32'h155);
    chk("rel_cnt", 32'(ifc.press_cnt), 32'd2);
    chk("rel_busy", 32'(ifc.busy), 32'd0);

    // bouncy press
    we0 = n_we;
    ifc.sw = 10'h0C3;
    for (int i = 0; i < 6; i++) begin
      ifc.key = (i % 2 == 0);
      step();
    end
    repeat (2) step();
    chk("bounce_nowe", 32'(n_we), 32'(we0));
    expect_press(10'h0C3);
    ifc.key = 1'b1;
    repeat (10) step();
    ifc.key = 1'b0;
    repeat (12) step();
    chk("bounce_we", 32'(n_we), 32'(we0 + 1));
    chk("bounce_cnt", 32'(ifc.press_cnt), 32'd3);

    // short glitch
    we0 = n_we;
    ifc.sw = 10'h111;
    ifc.key = 1'b1;
    repeat (3) step();
    ifc.key = 1'b0;
    repeat (10) step();
    chk("glitch_we", 32'(n_we), 32'(we0));
    chk("glitch_busy", 32'(ifc.busy), 32'd0);
    chk("glitch_data", 32'(ifc.data), 32'h0C3);
    chk("glitch_cnt", 32'(ifc.press_cnt), 32'd3);

    // reset mid-press, key held through release
    ifc.sw = 10'h2D2;
    ifc.key = 1'b1;
    repeat (4) step();
    chk("mid_busy", 32'(ifc.busy), 32'd1);
    rstn = 1'b0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("inrst_out",
          32'({ifc.we, ifc.busy, ifc.data, ifc.press_cnt}), 32'd0);
    end
    expect_press(10'h2D2);
    rstn = 1'b1;
    repeat (6) step();
    chk("rel_lat_early", 32'(ifc.we), 32'd0);
    step();
    chk("rel_lat_strobe", 32'(ifc.we), 32'd1);
    repeat (5) step();
    ifc.key = 1'b0;
    repeat (12) step();
    chk("rst_press_cnt", 32'(ifc.press_cnt), 32'd1);

    // wrap from zero
    rstn = 1'b0;
    exp_cnt = 8'd0;
    repeat (2) step();
    rstn = 1'b1;
    step();
    we0 = n_we;
    for (int i = 0; i < 256; i++)
      press(10'($urandom_range(1023)), 8);
    chk("wrap_cnt", 32'(ifc.press_cnt), 32'd0);
    chk("wrap_we", 32'(n_we - we0), 32'd256);

    repeat (4) step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_press_ctrl.md
KEY_PRESS_CTRL -- requirements
Module: key_press_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable synchronized samples (10 ms at 100 MHz) required to accept a press or release; legal range 2..2^20.
REQ-002 Port: clk100_i  input  1  system clock, 100 MHz; the only clock in the block.
REQ-003 Port: rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 Port: key_i  input  1  raw, unsynchronized, bouncing push-button; 1 = pressed.
REQ-005 Port: sw_i  input  10  switch word captured on each accepted press.
REQ-006 Port: we_o  output  1  one-cycle write strobe to the counter datapath.
REQ-007 Port: data_o  output  10  registered sw_i snapshot, valid from the we_o cycle onward.
REQ-008 Port: press_cnt_o  output  8  count of accepted presses, modulo 256.
REQ-009 Port: busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 key_i SHALL pass through a 2-FF synchronizer; its output is k_s. No other logic SHALL use key_i directly.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT; busy_o = (state != IDLE).
REQ-012 IDLE: k_s=1 -> PRESS_WAIT with the debounce counter cleared to 0.
REQ-013 PRESS_WAIT: k_s=0 -> IDLE with no strobe. k_s=1 -> counter increments. When k_s=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-014 On the PRESS_WAIT->PRESSED transition, the block SHALL register in the same edge: we_o=1 for exactly one cycle, data_o<=sw_i, press_cnt_o<=press_cnt_o+1.
REQ-015 Latency: with key_i stable high, we_o SHALL be high in the cycle after the (DEBOUNCE_CYCLES+3)th rising edge, counted from the first edge that samples key_i=1 as edge 1.
REQ-016 PRESSED: k_s=0 -> RELEASE_WAIT with the counter cleared. k_s=1 -> stay.
REQ-017 RELEASE_WAIT: k_s=1 -> PRESSED with no strobe. k_s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
REQ-018 Each accepted press SHALL produce exactly one we_o, regardless of hold time or bounce during the hold or release.
REQ-019 sw_i SHALL be sampled only in the strobe edge. data_o SHALL hold its value at all other times, and sw_i changes outside that edge SHALL have no effect.
REQ-020 press_cnt_o SHALL wrap from 255 to 0 with no flag.
REQ-021 The debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL never overflow.

Reset
REQ-022 While rstn_i=0: state=IDLE, both sync FFs=0, debounce counter=0, we_o=0, data_o=0, press_cnt_o=0, busy_o=0.
REQ-023 Assertion of rstn_i mid-press (any state) SHALL abort the press with no strobe.
REQ-024 A key held through reset release SHALL be treated as a new press and SHALL produce one we_o after the REQ-015 latency.

Structure
REQ-025 State encoding localparams and the width constants SW_W=10 and CNT_W=8 SHALL reside in shared package lab2_pkg.
REQ-026 The synchronizer SHALL be a separate sub-module, key_sync (2 FFs, async active-low reset to 0), instantiated once.

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-027 Clean press: sw_i=10'h2A5, key_i held 20 cycles -> single we_o 7 cycles after first sample, data_o=10'h2A5, press_cnt_o=1.
REQ-028 Bounce: key_i toggles 1/0 every cycle for 6 cycles, then held high 10 cycles -> no strobe during the bounce, then exactly one we_o, press_cnt_o +1.
REQ-029 Short glitch: key_i high for 3 cycles, then low -> no we_o, busy_o returns to 0, data_o and press_cnt_o unchanged.
REQ-030 Wrap: 256 clean presses -> press_cnt_o returns to 0; 256 we_o pulses counted.
REQ-031 Reset mid-press: rstn_i=0 for 4 cycles while in PRESS_WAIT, key still held -> all outputs 0 during reset; after release, one we_o and press_cnt_o=1.
REQ-032 Switch change while held: sw_i changes in PRESSED -> data_o keeps the value captured at the strobe.
